// File: rtl/ls_ctrl_pkg.sv
// Shared types and address/bit constants for the LightSeparator APB control block.
// The completed-frame counter address is only decoded when LS_FRAME_CNT_EN is defined.
package ls_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CTRL_ADDR      = 0;
  localparam int COEFF_BASE     = 1;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 1;
  localparam int CTRL_DONE_BIT  = 2;
  // Counter address sits just past the last coefficient register.
  localparam int FRAME_CNT_OFS  = 1;
  localparam int FRAME_CNT_W    = 16;

endpackage

// File: rtl/ls_apb_slave.sv
// Zero-wait-state APB decode: write strobes, coefficient select and registered PRDATA.
// With LS_FRAME_CNT_EN defined, the frame counter address is also decoded.
module ls_apb_slave
  import ls_ctrl_pkg::*;
#(
  parameter int Amba_Addr_Depth = 20,
  parameter int Amba_Word       = 24,
  parameter int CoeffPrecision  = 12,
  parameter int NumCoeffRegs    = 8,
  localparam int IdxW = (NumCoeffRegs > 1) ? $clog2(NumCoeffRegs) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [Amba_Addr_Depth-1:0]               PADDR,
  input  logic                                     PSEL,
  input  logic                                     PENABLE,
  input  logic                                     PWRITE,
  input  logic [2:0]                               ctrl_status,
  input  logic [2*NumCoeffRegs*CoeffPrecision-1:0] coeffs,
`ifdef LS_FRAME_CNT_EN
  input  logic [FRAME_CNT_W-1:0]                   frame_cnt,
  output logic                                     fcnt_wr,
`endif
  output logic [Amba_Word-1:0]                     PRDATA,
  output logic                                     ctrl_wr,
  output logic                                     coeff_wr,
  output logic [IdxW-1:0]                          coeff_sel
);

  logic setup, access, is_ctrl, is_coeff;
  logic [Amba_Word-1:0] rd_mux;

  assign setup     = PSEL & ~PENABLE;
  assign access    = PSEL & PENABLE;
  assign is_ctrl   = (PADDR == Amba_Addr_Depth'(CTRL_ADDR));
  assign is_coeff  = (PADDR >= Amba_Addr_Depth'(COEFF_BASE)) &&
                     (PADDR <  Amba_Addr_Depth'(COEFF_BASE + NumCoeffRegs));
  assign coeff_sel = IdxW'(PADDR - Amba_Addr_Depth'(COEFF_BASE));
  assign ctrl_wr   = access & PWRITE & is_ctrl;
  assign coeff_wr  = access & PWRITE & is_coeff;

`ifdef LS_FRAME_CNT_EN
  logic is_fcnt;
  assign is_fcnt = (PADDR == Amba_Addr_Depth'(NumCoeffRegs + FRAME_CNT_OFS));
  assign fcnt_wr = access & PWRITE & is_fcnt;
`endif

  always_comb begin
    rd_mux = '0;
    if (is_ctrl)
      rd_mux = Amba_Word'(ctrl_status);
    else if (is_coeff)
      rd_mux = Amba_Word'(coeffs[coeff_sel*2*CoeffPrecision +: 2*CoeffPrecision]);
`ifdef LS_FRAME_CNT_EN
    else if (is_fcnt)
      rd_mux = Amba_Word'(frame_cnt);
`endif
  end

  // Captured in the read setup phase and held through access; zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      PRDATA <= '0;
    else if (setup && !PWRITE)
      PRDATA <= rd_mux;
    else if (!(access && !PWRITE))
      PRDATA <= '0;
  end

endmodule

// File: rtl/ls_apb_ctrl_regfile.sv
// APB register bank and frame-streaming FSM at the LightSeparator input boundary.
// Define LS_FRAME_CNT_EN to add a 16-bit saturating completed-frame counter.
//
//   state  | meaning
//   IDLE   | waiting for a 0->1 edge on start_work
//   STREAM | forwarding FrameLen pixels, abort if start_work clears
//   DONE   | frame_done pulsed once, wait for start_work to clear
module ls_apb_ctrl_regfile
  import ls_ctrl_pkg::*;
#(
  parameter int Amba_Addr_Depth = 20,
  parameter int Amba_Word       = 24,
  parameter int PixelPrecision  = 8,
  parameter int CoeffPrecision  = 12,
  parameter int NumCoeffRegs    = 8,
  parameter int FrameLen        = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [Amba_Addr_Depth-1:0]               PADDR,
  input  logic                                     PSEL,
  input  logic                                     PENABLE,
  input  logic                                     PWRITE,
  input  logic [Amba_Word-1:0]                     PWDATA,
  output logic [Amba_Word-1:0]                     PRDATA,
  input  logic [PixelPrecision-1:0]                ImInput,
  output logic [2*NumCoeffRegs*CoeffPrecision-1:0] coeffs,
  output logic [PixelPrecision-1:0]                pix_out,
  output logic                                     pix_valid,
  output logic                                     pix_first,
  output logic                                     pix_last,
  output logic                                     busy,
  output logic                                     frame_done
);

  localparam int IdxW = (NumCoeffRegs > 1) ? $clog2(NumCoeffRegs) : 1;
  localparam int CntW = (FrameLen > 1) ? $clog2(FrameLen) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

  state_t            state;
  logic [CntW-1:0]   cnt;
  logic              start_work, start_d, sticky;
  logic              ctrl_wr, coeff_wr;
  logic [IdxW-1:0]   coeff_sel;
  logic [2:0]        ctrl_status;

  always_comb begin
    ctrl_status = '0;
    ctrl_status[CTRL_START_BIT] = start_work;
    ctrl_status[CTRL_BUSY_BIT]  = busy;
    ctrl_status[CTRL_DONE_BIT]  = sticky;
  end

`ifdef LS_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   fcnt_wr;
`endif

  ls_apb_slave #(
    .Amba_Addr_Depth(Amba_Addr_Depth),
    .Amba_Word      (Amba_Word),
    .CoeffPrecision (CoeffPrecision),
    .NumCoeffRegs   (NumCoeffRegs)
  ) u_apb (
    .clk        (clk),
    .rst        (rst),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .ctrl_status(ctrl_status),
    .coeffs     (coeffs),
`ifdef LS_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
    .fcnt_wr    (fcnt_wr),
`endif
    .PRDATA     (PRDATA),
    .ctrl_wr    (ctrl_wr),
    .coeff_wr   (coeff_wr),
    .coeff_sel  (coeff_sel)
  );

  // Coefficients are frozen while a frame is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coeffs     <= '0;
      start_work <= 1'b0;
      start_d    <= 1'b0;
    end else begin
      start_d <= start_work;
      if (ctrl_wr)
        start_work <= PWDATA[CTRL_START_BIT];
      if (coeff_wr && !busy)
        coeffs[coeff_sel*2*CoeffPrecision +: 2*CoeffPrecision] <= PWDATA[2*CoeffPrecision-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      pix_out    <= '0;
      pix_valid  <= 1'b0;
      pix_first  <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
      sticky     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pix_out    <= '0;
          pix_valid  <= 1'b0;
          pix_first  <= 1'b0;
          pix_last   <= 1'b0;
          frame_done <= 1'b0;
          if (start_work && !start_d) begin
            state <= STREAM;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        STREAM: begin
          frame_done <= 1'b0;
          if (!start_work) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            pix_first <= 1'b0;
            pix_last  <= 1'b0;
          end else begin
            pix_out   <= ImInput;
            pix_valid <= 1'b1;
            pix_first <= (cnt == '0);
            pix_last  <= (cnt == LastCnt);
            if (cnt == LastCnt)
              state <= DONE;
            else
              cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // pix_last is still high only on the first DONE cycle.
          pix_out    <= '0;
          pix_valid  <= 1'b0;
          pix_first  <= 1'b0;
          pix_last   <= 1'b0;
          frame_done <= pix_last;
          if (!start_work) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (ctrl_wr && !PWDATA[CTRL_START_BIT])
        sticky <= 1'b0;
      else if (state == DONE && pix_last)
        sticky <= 1'b1;
    end
  end

`ifdef LS_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      frame_cnt <= '0;
    else if (fcnt_wr)
      frame_cnt <= '0;
    else if (state == DONE && pix_last && frame_cnt != '1)
      frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ls_apb_ctrl_regfile.sv
// Self-checking bench for ls_apb_ctrl_regfile: random APB traffic and pixel data
// checked against a transaction-level model of the register map and frame timing.
module tb_ls_apb_ctrl_regfile;

  localparam int AW = 20, DW = 24, PW = 8, CP = 12, NR = 8, FL = 32;
  localparam int NEVER = 1 << 30;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     PADDR;
  logic              PSEL, PENABLE, PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA;
  logic [PW-1:0]     ImInput;
  logic [2*NR*CP-1:0] coeffs;
  logic [PW-1:0]     pix_out;
  logic              pix_valid, pix_first, pix_last, busy, frame_done;

  always #5 clk = ~clk;

  ls_apb_ctrl_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .ImInput   (ImInput),
    .coeffs    (coeffs),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_first (pix_first),
    .pix_last  (pix_last),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  logic [PW-1:0] im_at [1024];

  // reference model state
  logic [DW-1:0] coeff_m [1:NR];
  bit  start_m, sticky_m;
  int  fcnt_m;
  bit  active;
  int  t_start, end_edge;
  int  last_wr_edge;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    ImInput = '0;
    forever begin
      @(negedge clk);
      ImInput = PW'($urandom);
      im_at[(cyc + 1) % 1024] = ImInput;
    end
  end

  // Frame timing from the start write edge T: pixel i appears after edge T+2+i,
  // frame_done after edge T+FL+2, busy from T+1 until the stop edge is seen.
  int  mc, mk;
  bit  ev, eb, ef;
  initial begin
    forever begin
      @(negedge clk);
      mc = cyc;
      ev = active && mc >= t_start + 2 && mc <= t_start + FL + 1 && mc <= end_edge;
      eb = active && mc >= t_start + 1 && mc <= end_edge;
      ef = active && mc == t_start + FL + 2 && mc <= end_edge;
      check_val("pix_valid", 64'(pix_valid), 64'(ev));
      check_val("busy", 64'(busy), 64'(eb));
      check_val("frame_done", 64'(frame_done), 64'(ef));
      if (ev) begin
        mk = mc - t_start - 2;
        check_val("pix_out", 64'(pix_out), 64'(im_at[mc % 1024]));
        check_val("pix_first", 64'(pix_first), 64'(mk == 0));
        check_val("pix_last", 64'(pix_last), 64'(mk == FL - 1));
      end
    end
  end

  task automatic apb_write(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(a); PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    last_wr_edge = cyc + 1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input int a, output logic [DW-1:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = AW'(a);
    @(negedge clk);
    PENABLE = 1'b1;
    d = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_rd(input int a, input bit b);
    if (a == 0) return {21'd0, sticky_m, b, start_m};
    if (a >= 1 && a <= NR) return coeff_m[a];
`ifdef LS_FRAME_CNT_EN
    if (a == NR + 1) return DW'(fcnt_m);
`endif
    return '0;
  endfunction

  task automatic model_wr(input int a, input logic [DW-1:0] d);
    if (a >= 1 && a <= NR) coeff_m[a] = d;
    if (a == NR + 1) fcnt_m = 0;
  endtask

  task automatic model_reset();
    for (int k = 1; k <= NR; k++) coeff_m[k] = '0;
    start_m = 0; sticky_m = 0; fcnt_m = 0; active = 0;
  endtask

  task automatic check_coeffs();
    for (int k = 1; k <= NR; k++)
      check_val($sformatf("coeffs_reg%0d", k), 64'(coeffs[(k-1)*2*CP +: 2*CP]), 64'(coeff_m[k]));
  endtask

  task automatic read_check(input int a, input bit b, input string tag);
    logic [DW-1:0] d;
    apb_read(a, d);
    check_val(tag, 64'(d), 64'(model_rd(a, b)));
  endtask

  task automatic start_frame();
    apb_write(0, 24'hFFFFFF);
    start_m = 1; t_start = last_wr_edge; end_edge = NEVER; active = 1;
  endtask

  task automatic stop_frame();
    apb_write(0, 24'h000000);
    start_m = 0; sticky_m = 0; end_edge = last_wr_edge;
  endtask

  task automatic run_full_frame();
    logic [DW-1:0] keep;
    start_frame();
    keep = coeff_m[2];
    apb_write(2, 24'hFFFFFF);
    read_check(2, 1'b1, "coeff_write_while_busy");
    check_val("coeff2_unchanged", 64'(coeff_m[2]), 64'(keep));
    while (cyc < t_start + FL + 4) @(negedge clk);
    sticky_m = 1;
    if (fcnt_m < 16'hFFFF) fcnt_m++;
    read_check(0, 1'b1, "ctrl_after_done");
    check_coeffs();
    read_check(NR + 1, 1'b0, "frame_cnt_after_frame");
    stop_frame();
    repeat (2) @(negedge clk);
    read_check(0, 1'b0, "ctrl_after_clear");
  endtask

  initial begin
    logic [DW-1:0] d;
    int a;
    rst = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    model_reset();
    t_start = 0; end_edge = NEVER; last_wr_edge = 0;
    repeat (3) @(negedge clk);
    check_val("rst_prdata", 64'(PRDATA), 64'd0);
    check_val("rst_pix_out", 64'(pix_out), 64'd0);
    check_val("rst_first_last", 64'({pix_first, pix_last}), 64'd0);
    check_val("rst_coeffs_zero", 64'(|coeffs), 64'd0);
    @(posedge clk); #2 rst = 1'b1;

    for (int i = 0; i <= NR; i++) read_check(i, 1'b0, "read_after_reset");

    apb_write(1, 24'h7FF801); model_wr(1, 24'h7FF801);
    apb_write(8, 24'h123ABC); model_wr(8, 24'h123ABC);
    read_check(1, 1'b0, "coeff1_readback");
    read_check(8, 1'b0, "coeff8_readback");
    check_val("coeffs_lo_reg1", 64'(coeffs[11:0]), 64'h801);
    check_val("coeffs_hi_reg1", 64'(coeffs[23:12]), 64'h7FF);
    check_val("coeffs_hi_reg8", 64'(coeffs[191:180]), 64'h123);
    @(negedge clk);
    check_val("prdata_idle_zero", 64'(PRDATA), 64'd0);

    apb_write(9, 24'h5A5A5A); model_wr(9, 24'h5A5A5A);
    read_check(9, 1'b0, "addr9_after_write");

    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(1, 15);
      d = DW'($urandom);
      apb_write(a, d);
      model_wr(a, d);
    end
    for (int i = 0; i < 16; i++) read_check(i, 1'b0, "rand_readback");
    for (int i = 0; i < 4; i++) read_check($urandom_range(16, (1 << AW) - 1), 1'b0, "unmapped_read");
    check_coeffs();

    run_full_frame();

    // abort after ten pixels
    start_frame();
    while (cyc < t_start + 8) @(negedge clk);
    apb_write(0, 24'h000000);
    start_m = 0; end_edge = last_wr_edge;
    check_val("abort_pixels", 64'(end_edge - t_start - 1), 64'd10);
    repeat (3) @(negedge clk);
    read_check(0, 1'b0, "ctrl_after_abort");

    // async reset in the middle of a frame
    start_frame();
    while (cyc < t_start + 15) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    model_reset();
    #1;
    check_val("midrst_valid", 64'(pix_valid), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_coeffs", 64'(|coeffs), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    read_check(1, 1'b0, "coeff1_after_midrst");

    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(1, NR);
      d = DW'($urandom);
      apb_write(a, d);
      model_wr(a, d);
    end
    run_full_frame();
    apb_write(NR + 1, DW'($urandom)); model_wr(NR + 1, '0);
    read_check(NR + 1, 1'b0, "frame_cnt_cleared");
    for (int i = 0; i < 16; i++) read_check(i, 1'b0, "final_readback");

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
